// File: rtl/fifo_rd_arb.sv
// fifo_rd_arb: read-side scheduler for the async FIFO.
// Shares one FIFO read port among N consumers with round-robin burst grants.
// Each popped word goes into a one-entry output register that is steered to
// the granted consumer with a valid/ready handshake.
// Optional: `define FIFO_RD_ARB_PRIO0_EN gives consumer 0 strict priority.
module fifo_rd_arb #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int BURST_LEN = 4
) (
  input  logic          rclk,
  input  logic          rrst_n,
  input  logic          rempty,
  input  logic [DW-1:0] rdata,
  output logic          rinc,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  rd_ready,
  output logic [DW-1:0] out_data,
  output logic [N-1:0]  out_valid,
  output logic [N-1:0]  gnt,
  output logic          burst_done
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] BL = CW'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t        state, state_d;
  logic [GW-1:0] gidx, gidx_d, rr_ptr, rr_ptr_d, pick;
  logic [CW-1:0] cnt, cnt_d;
  logic [N-1:0]  gnt_d, out_valid_d;
  logic [DW-1:0] out_data_d;
  logic          burst_done_d, pick_vld;
  logic          ovld, accept, free;

  // Output-register handshake; rinc only when the register can take a word.
  assign ovld   = |out_valid;
  assign accept = ovld & rd_ready[gidx];
  assign free   = !ovld | accept;
  assign rinc   = (state == BURST) & !rempty & free & req[gidx] & (cnt < BL);

  // Next winner: first requester after the last round-robin grant, wrapping.
  always_comb begin
    logic [GW-1:0] idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N; k++) begin
      idx = GW'((int'(rr_ptr) + k) % N);
      if (!pick_vld && req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
`ifdef FIFO_RD_ARB_PRIO0_EN
    if (req[0]) begin
      pick     = '0;
      pick_vld = 1'b1;
    end
`endif
  end

  // FSM next state, pop bookkeeping and output-register updates.
  always_comb begin
    state_d      = state;
    gidx_d       = gidx;
    rr_ptr_d     = rr_ptr;
    cnt_d        = cnt;
    gnt_d        = gnt;
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    burst_done_d = 1'b0;
    if (rinc) begin
      out_data_d  = rdata;
      out_valid_d = gnt;
      cnt_d       = cnt + 1'b1;
    end else if (accept) begin
      out_valid_d = '0;
    end
    case (state)
      IDLE: if (pick_vld) begin
        gidx_d        = pick;
        gnt_d         = '0;
        gnt_d[pick]   = 1'b1;
        cnt_d         = '0;
        state_d       = BURST;
`ifdef FIFO_RD_ARB_PRIO0_EN
        // A priority grant to consumer 0 leaves the rotation untouched.
        if (!req[0]) rr_ptr_d = pick;
`else
        rr_ptr_d      = pick;
`endif
      end
      // Leave on the last pop of the burst, requester gone, or FIFO ran dry
      // after at least one word; an empty FIFO before any word just waits.
      BURST: if ((rinc && (cnt + 1'b1 == BL)) || !req[gidx] ||
                 (rempty && cnt != '0)) state_d = DRAIN;
      // Hold the grant until the last word has been taken.
      DRAIN: if (free) begin
        gnt_d        = '0;
        burst_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any held word and the grant.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state      <= IDLE;
      gidx       <= '0;
      rr_ptr     <= GW'(N - 1);
      cnt        <= '0;
      gnt        <= '0;
      out_valid  <= '0;
      out_data   <= '0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_d;
      gidx       <= gidx_d;
      rr_ptr     <= rr_ptr_d;
      cnt        <= cnt_d;
      gnt        <= gnt_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      burst_done <= burst_done_d;
    end
  end
endmodule
